// File: rtl/pid_error_stage.sv
// pid_error_stage: PID front end. Turns unsigned setpoint/measurement samples
// into signed error, delta (error - previous error) and a saturating integral.
// Two-stage pipeline: stage 1 forms the error, stage 2 updates history and integral.
// Optional feature macro: PID_INTEG_SAT_FLAG_EN adds integ_sat_out, which flags
// that the latest integral update was clamped.
module pid_error_stage #(
  parameter int unsigned UNSIGNED_WIDTH = 8,
  parameter int unsigned INTEG_WIDTH    = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_valid_in,
  input  logic [UNSIGNED_WIDTH-1:0]        measurement_in,
  input  logic [UNSIGNED_WIDTH-1:0]        setpoint_in,
  input  logic                             clear_in,
  output logic signed [UNSIGNED_WIDTH:0]   error_out,
  output logic signed [UNSIGNED_WIDTH+1:0] delta_out,
  output logic signed [INTEG_WIDTH-1:0]    integral_out,
`ifdef PID_INTEG_SAT_FLAG_EN
  output logic                             integ_sat_out,
`endif
  output logic                             valid_out
);

  localparam int unsigned W = UNSIGNED_WIDTH;
  localparam int unsigned I = INTEG_WIDTH;

  // Stage-1 and history state
  logic signed [W:0]   r_err1;
  logic                r_v1;
  logic signed [W:0]   r_prev_err;
  logic                r_hist_valid;
  logic signed [I-1:0] r_integral;

  // Combinational datapath
  logic signed [W:0]   w_err_new;
  logic signed [W+1:0] w_delta;
  logic        [I:0]   w_integ_sum;
  logic                w_integ_sat;
  logic signed [I-1:0] w_integ_next;

  // Error, delta and clamped integral; the integral sum carries one guard bit
  // so an overflow shows up as a disagreement between its top two bits.
  always_comb begin
    w_err_new    = (W+1)'({1'b0, setpoint_in}) - (W+1)'({1'b0, measurement_in});
    w_delta      = {r_err1[W], r_err1} - {r_prev_err[W], r_prev_err};
    w_integ_sum  = {r_integral[I-1], r_integral} + {{(I-W){r_err1[W]}}, r_err1};
    w_integ_sat  = w_integ_sum[I] ^ w_integ_sum[I-1];
    w_integ_next = w_integ_sum[I-1:0];
    if (w_integ_sat) begin
      if (w_integ_sum[I]) begin
        w_integ_next = {1'b1, {(I-1){1'b0}}};
      end else begin
        w_integ_next = {1'b0, {(I-1){1'b1}}};
      end
    end
  end

  assign integral_out = r_integral;

  // Pipeline registers; clear drops anything in flight and wipes history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err1       <= '0;
      r_v1         <= 1'b0;
      r_prev_err   <= '0;
      r_hist_valid <= 1'b0;
      r_integral   <= '0;
      error_out    <= '0;
      delta_out    <= '0;
      valid_out    <= 1'b0;
`ifdef PID_INTEG_SAT_FLAG_EN
      integ_sat_out <= 1'b0;
`endif
    end else if (clear_in) begin
      r_err1       <= '0;
      r_v1         <= 1'b0;
      r_prev_err   <= '0;
      r_hist_valid <= 1'b0;
      r_integral   <= '0;
      error_out    <= '0;
      delta_out    <= '0;
      valid_out    <= 1'b0;
`ifdef PID_INTEG_SAT_FLAG_EN
      integ_sat_out <= 1'b0;
`endif
    end else begin
      r_v1      <= sample_valid_in;
      valid_out <= r_v1;
      if (sample_valid_in) begin
        r_err1 <= w_err_new;
      end
      if (r_v1) begin
        error_out    <= r_err1;
        delta_out    <= r_hist_valid ? w_delta : '0;
        r_prev_err   <= r_err1;
        r_hist_valid <= 1'b1;
        r_integral   <= w_integ_next;
`ifdef PID_INTEG_SAT_FLAG_EN
        integ_sat_out <= w_integ_sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pid_error_stage.sv
// Testbench for pid_error_stage: directed test-plan scenarios with literal
// expectations, then randomized traffic against an integer reference model.
module tb_pid_error_stage;

  localparam int unsigned W = 8;
  localparam int unsigned I = 12;
  localparam int IMAX = (1 << (I - 1)) - 1;
  localparam int IMIN = -(1 << (I - 1));

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                sample_valid_in = 1'b0;
  logic [W-1:0]        measurement_in = '0;
  logic [W-1:0]        setpoint_in = '0;
  logic                clear_in = 1'b0;
  logic signed [W:0]   error_out;
  logic signed [W+1:0] delta_out;
  logic signed [I-1:0] integral_out;
  logic                valid_out;
  int                  sat_obs;
`ifdef PID_INTEG_SAT_FLAG_EN
  logic                integ_sat_out;
  assign sat_obs = int'(integ_sat_out);
`else
  assign sat_obs = 0;
`endif

  pid_error_stage #(.UNSIGNED_WIDTH(W), .INTEG_WIDTH(I)) dut (
    .clk             (clk),
    .reset           (reset),
    .sample_valid_in (sample_valid_in),
    .measurement_in  (measurement_in),
    .setpoint_in     (setpoint_in),
    .clear_in        (clear_in),
    .error_out       (error_out),
    .delta_out       (delta_out),
    .integral_out    (integral_out),
`ifdef PID_INTEG_SAT_FLAG_EN
    .integ_sat_out   (integ_sat_out),
`endif
    .valid_out       (valid_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (integer arithmetic) ----------------
  typedef struct { int stamp; int err; } pend_t;
  pend_t pipe[$];
  int edge_cnt = 0;
  int m_valid = 0, m_err = 0, m_delta = 0, m_integ = 0, m_sat = 0;
  int m_prev = 0;
  bit m_hist = 0;

  always @(posedge clk or posedge reset) begin
    if (reset || clear_in) begin
      pipe.delete();
      m_valid = 0; m_err = 0; m_delta = 0; m_integ = 0; m_sat = 0;
      m_prev = 0; m_hist = 0;
    end else begin
      m_valid = 0;
      if (pipe.size() > 0 && pipe[0].stamp == edge_cnt - 1) begin
        pend_t p;
        int s;
        p = pipe.pop_front();
        m_valid = 1;
        m_err   = p.err;
        m_delta = m_hist ? p.err - m_prev : 0;
        m_prev  = p.err;
        m_hist  = 1;
        s = m_integ + p.err;
        m_sat = (s > IMAX || s < IMIN) ? 1 : 0;
        m_integ = (s > IMAX) ? IMAX : (s < IMIN) ? IMIN : s;
      end
      if (sample_valid_in)
        pipe.push_back('{edge_cnt, int'(setpoint_in) - int'(measurement_in)});
    end
    if (!reset) edge_cnt++;
  end

  // ---------------- per-cycle comparison + observation log ----------------
  typedef struct { int e; int d; int i; int s; } obs_t;
  obs_t obs_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      chk("valid_out", int'(valid_out), m_valid);
      chk("error_out", int'(error_out), m_err);
      chk("delta_out", int'(delta_out), m_delta);
      chk("integral_out", int'(integral_out), m_integ);
`ifdef PID_INTEG_SAT_FLAG_EN
      chk("integ_sat_out", sat_obs, m_sat);
`endif
      if (valid_out)
        obs_q.push_back('{int'(error_out), int'(delta_out), int'(integral_out), sat_obs});
    end
  end

  // ---------------- stimulus helpers (called at #1 after posedge) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input int sp, input int m);
    sample_valid_in = 1'b1;
    setpoint_in     = W'(sp);
    measurement_in  = W'(m);
    @(posedge clk); #1;
    sample_valid_in = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_in = 1'b1;
    @(posedge clk); #1;
    clear_in = 1'b0;
  endtask

  task automatic chk_obs(input string name, input int idx, input int e, input int d, input int i);
    if (idx >= obs_q.size()) begin
      chk({name, "_present"}, obs_q.size(), idx + 1);
    end else begin
      chk({name, "_err"}, obs_q[idx].e, e);
      chk({name, "_delta"}, obs_q[idx].d, d);
      chk({name, "_integ"}, obs_q[idx].i, i);
    end
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_valid"}, int'(valid_out), 0);
    chk({name, "_err"}, int'(error_out), 0);
    chk({name, "_delta"}, int'(delta_out), 0);
    chk({name, "_integ"}, int'(integral_out), 0);
    chk({name, "_sat"}, sat_obs, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;
    idle(2);
    chk_zero_outputs("post_reset");

    // 1/2: basic and second sample
    obs_q.delete();
    strobe(128, 100);
    idle(3);
    chk("t1_count", obs_q.size(), 1);
    chk_obs("t1", 0, 28, 0, 28);
    obs_q.delete();
    strobe(128, 140);
    idle(3);
    chk_obs("t2", 0, -12, -40, 16);

    // 3: back-to-back strobes after a clear
    pulse_clear();
    obs_q.delete();
    strobe(10, 0);
    strobe(10, 5);
    strobe(10, 20);
    idle(4);
    chk("t3_count", obs_q.size(), 3);
    chk_obs("t3a", 0, 10, 0, 10);
    chk_obs("t3b", 1, 5, -5, 15);
    chk_obs("t3c", 2, -10, -15, 5);

    // 4: positive then negative saturation
    pulse_clear();
    obs_q.delete();
    repeat (10) strobe(255, 0);
    idle(3);
    chk("t4p_count", obs_q.size(), 10);
    chk_obs("t4p_8", 7, 255, 0, 2040);
    chk_obs("t4p_9", 8, 255, 0, 2047);
    chk_obs("t4p_10", 9, 255, 0, 2047);
`ifdef PID_INTEG_SAT_FLAG_EN
    if (obs_q.size() == 10) begin
      chk("t4p_sat8", obs_q[7].s, 0);
      chk("t4p_sat9", obs_q[8].s, 1);
    end
`endif
    pulse_clear();
    obs_q.delete();
    repeat (10) strobe(0, 255);
    idle(3);
    chk_obs("t4n_8", 7, -255, 0, -2040);
    chk_obs("t4n_9", 8, -255, 0, -2048);
    chk_obs("t4n_10", 9, -255, 0, -2048);

    // 5: clear with a sample in stage 1 and a sample strobed alongside
    obs_q.delete();
    sample_valid_in = 1'b1; setpoint_in = 8'd1; measurement_in = 8'd0;
    @(posedge clk); #1;
    clear_in = 1'b1; setpoint_in = 8'd2;
    @(posedge clk); #1;
    clear_in = 1'b0; sample_valid_in = 1'b0;
    idle(3);
    chk("t5_dropped", obs_q.size(), 0);
    chk_zero_outputs("t5_cleared");
    strobe(50, 40);
    idle(3);
    chk_obs("t5_next", 0, 10, 0, 10);

    // 6: async reset between strobe and valid_out
    obs_q.delete();
    strobe(60, 40);
    #2 reset = 1'b1;
    #1 chk_zero_outputs("t6_async");
    @(posedge clk); #1;
    reset = 1'b0;
    idle(3);
    chk("t6_dropped", obs_q.size(), 0);
    strobe(60, 40);
    idle(3);
    chk_obs("t6_next", 0, 20, 0, 20);

    // Randomized traffic, biased toward extremes to reach both clamps
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        #2 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        clear_in        = (r >= 3 && r < 20);
        sample_valid_in = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 3) == 0) begin
          setpoint_in    = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
          measurement_in = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        end else begin
          setpoint_in    = W'($urandom);
          measurement_in = W'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    clear_in = 1'b0;
    sample_valid_in = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
